// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed hex display: register select
// encoding, CTRL bit layout and the active-low 7-segment glyph table.
// Latency: n/a (types and constants only). Backpressure: n/a.
package display_pkg;

  // Register select seen on the bus reg_sel line.
  typedef enum logic {
    REG_DATA = 1'b0,
    REG_CTRL = 1'b1
  } reg_sel_e;

  // CTRL register bit positions.
  localparam int EN_BIT  = 0;
  localparam int LZB_BIT = 1;
  localparam int DP_LSB  = 8;

  // Stored CTRL fields; every other CTRL bit is not stored and reads 0.
  typedef struct packed {
    logic [7:0] dp;   // per-digit decimal point enables
    logic       lzb;  // leading-zero blanking
    logic       en;   // display enable
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{dp: 8'h00, lzb: 1'b0, en: 1'b1};

  // Active-low glyphs for 0..F; bit7 is the (unlit) DP position, bits 6:0 are G..A.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Place the stored CTRL fields at their architectural bit positions.
  function automatic logic [31:0] ctrl_readback(input ctrl_t c);
    logic [31:0] r;
    r               = '0;
    r[EN_BIT]       = c.en;
    r[LZB_BIT]      = c.lzb;
    r[DP_LSB +: 8]  = c.dp;
    return r;
  endfunction

endpackage

// File: rtl/hex_display_mux_if.sv
// Register bus between the bridge digit port and the hex display.
// Ports: we (write strobe), reg_sel (DATA/CTRL), wdata (32b), rdata (32b read-back).
// Latency: rdata is combinational; writes take effect at the next clock edge; no stalls.
interface hex_display_mux_if;
  logic        we;
  logic        reg_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Bridge side drives the strobe and write data, samples read-back.
  modport master (output we, output reg_sel, output wdata, input rdata);
  // Display side.
  modport slave  (input we, input reg_sel, input wdata, output rdata);
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment lookup (A in bit 0 .. G in bit 6).
// Ports: nib (4b hex value in), seg (7b active-low segments out).
// Latency: purely combinational. Backpressure: none.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // DP lives in bit 7 of the table and is handled by the caller.
  assign seg = SEG_TABLE[nib][6:0];

endmodule

// File: rtl/hex_display_mux.sv
// Multiplexed common-anode hex display with bus-writable DATA and CTRL registers.
// Ports: clk, rst (sync, active high), bus (slave register port),
//        dig_en (active-low digit enables), seg (active-low segments, seg[7]=DP).
// Latency: dig_en/seg registered, 1 cycle after an idx change or register write;
// writes always accepted, no backpressure.
module hex_display_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,     // 1..8
  parameter int SCAN_DIV   = 50000  // clk cycles per digit slot, >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_display_mux_if.slave      bus,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [7:0]            seg
);

  localparam int PW = $clog2(SCAN_DIV);

  // Registers
  logic [31:0]           data_q;
  ctrl_t                 ctrl_q;
  logic [PW-1:0]         psc_q, psc_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [7:0]            seg_q, seg_d;

  // Combinational helpers
  logic                  tick;
  logic [NUM_DIGITS-1:0] blank;
  logic                  tail_zero;
  logic [3:0]            nib_sel;
  logic                  blank_sel;
  logic                  dp_sel;
  logic [6:0]            seg_raw;

  // ---------------------------------------------------------------------------
  // Bus registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= CTRL_RST;
    end else if (bus.we) begin
      if (bus.reg_sel == REG_CTRL) begin
        ctrl_q.en  <= bus.wdata[EN_BIT];
        ctrl_q.lzb <= bus.wdata[LZB_BIT];
        ctrl_q.dp  <= bus.wdata[DP_LSB +: 8];
      end else begin
        data_q <= bus.wdata;
      end
    end
  end

  // Read-back reflects whatever the last edge stored.
  assign bus.rdata = (bus.reg_sel == REG_CTRL) ? ctrl_readback(ctrl_q) : data_q;

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  assign tick = (psc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    psc_d = psc_q;
    idx_d = idx_q;
    if (!ctrl_q.en) begin
      // Parked at digit 0 so re-enabling starts a fresh, full slot.
      psc_d = '0;
      idx_d = '0;
    end else if (tick) begin
      psc_d = '0;
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      psc_d = psc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
      idx_q <= '0;
    end else begin
      psc_q <= psc_d;
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking
  // Walk from the top digit down: a digit is a leading zero while every nibble
  // from it upwards is zero. A lit DP keeps the digit visible; digit 0 always shows.
  // ---------------------------------------------------------------------------
  always_comb begin
    blank     = '0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero & (data_q[4*i +: 4] == 4'h0);
      blank[i]  = ctrl_q.lzb & tail_zero & ~ctrl_q.dp[i] & (i != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection
  // ---------------------------------------------------------------------------
  always_comb begin
    nib_sel   = 4'h0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        nib_sel   = data_q[4*i +: 4];
        blank_sel = blank[i];
        dp_sel    = ctrl_q.dp[i];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .nib (nib_sel),
    .seg (seg_raw)
  );

  // ---------------------------------------------------------------------------
  // Output drive: one digit low at a time; disabled or blanked slots drive
  // everything off but still consume the slot time.
  // ---------------------------------------------------------------------------
  always_comb begin
    dig_en_d = '1;
    seg_d    = 8'hFF;
    if (ctrl_q.en && !blank_sel) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == 3'(i)) begin
          dig_en_d[i] = 1'b0;
        end
      end
      seg_d = {~dp_sel, seg_raw};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en_q <= '1;
      seg_q    <= 8'hFF;
    end else begin
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed plus randomized bench for hex_display_mux (4 digits, 4-cycle slots).
// Inputs are driven at the falling edge, outputs checked at the falling edge
// against constants and a behavioural display model.
module tb_hex_display_mux;

  localparam int ND = 4;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig_en;
  logic [7:0] seg;

  int n_cmp  = 0;
  int n_fail = 0;

  hex_display_mux_if bus ();

  hex_display_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dig_en (dig_en),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: register contents, position within the scan, and the
  // display the model expects to see after the most recent edge.
  // ---------------------------------------------------------------------------
  logic [31:0] m_data;
  logic        m_en;
  logic        m_lzb;
  logic [7:0]  m_dp;
  int          m_idx;
  int          m_psc;
  logic [3:0]  m_dig;
  logic [7:0]  m_seg;

  function automatic logic [7:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // What digit `idx` should look like given the register contents.
  function automatic logic [11:0] ref_show(input int idx, input logic [31:0] data,
                                           input logic en, input logic lzb,
                                           input logic [7:0] dp);
    logic [3:0] nib;
    logic       dp_on;
    logic       blanked;
    logic [7:0] g;
    if (!en) return {4'hF, 8'hFF};
    nib   = 4'(data >> (4 * idx));
    dp_on = ((dp >> idx) & 8'h01) != 8'h00;
    blanked = 1'b0;
    if (lzb && idx > 0 && !dp_on) begin
      blanked = 1'b1;
      for (int j = idx; j < ND; j++)
        if (4'(data >> (4 * j)) != 4'h0) blanked = 1'b0;
    end
    if (blanked) return {4'hF, 8'hFF};
    g    = ref_glyph(nib);
    g[7] = ~dp_on;
    return {~(4'b0001 << idx), g};
  endfunction

  function automatic logic [31:0] ref_rdata(input logic sel);
    if (sel) return {16'h0000, m_dp, 6'b000000, m_lzb, m_en};
    return m_data;
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    if (rst) begin
      m_data = '0;  m_en = 1'b1;  m_lzb = 1'b0;  m_dp = '0;
      m_idx  = 0;   m_psc = 0;    m_dig = 4'hF;  m_seg = 8'hFF;
    end else begin
      {m_dig, m_seg} = ref_show(m_idx, m_data, m_en, m_lzb, m_dp);
      if (!m_en) begin
        m_idx = 0;  m_psc = 0;
      end else if (m_psc == SD - 1) begin
        m_psc = 0;  m_idx = (m_idx + 1) % ND;
      end else begin
        m_psc = m_psc + 1;
      end
      if (bus.we) begin
        if (bus.reg_sel) begin
          m_en  = bus.wdata[0];
          m_lzb = bus.wdata[1];
          m_dp  = bus.wdata[15:8];
        end else begin
          m_data = bus.wdata;
        end
      end
    end
  endtask

  task automatic check_model();
    n_cmp++;
    assert ({dig_en, seg} === {m_dig, m_seg}) else begin
      n_fail++;
      $error("FAIL model_out: dig_en=%b seg=%h, expected dig_en=%b seg=%h",
             dig_en, seg, m_dig, m_seg);
    end
    n_cmp++;
    assert (bus.rdata === ref_rdata(bus.reg_sel)) else begin
      n_fail++;
      $error("FAIL model_rdata(sel=%0d): rdata=%h, expected %h",
             bus.reg_sel, bus.rdata, ref_rdata(bus.reg_sel));
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic [7:0] s);
    n_cmp++;
    assert ({dig_en, seg} === {d, s}) else begin
      n_fail++;
      $error("FAIL %s: dig_en=%b seg=%h, expected dig_en=%b seg=%h", tag, dig_en, seg, d, s);
    end
  endtask

  task automatic expect_rdata(input string tag, input logic [31:0] v);
    n_cmp++;
    assert (bus.rdata === v) else begin
      n_fail++;
      $error("FAIL %s: rdata=%h, expected %h", tag, bus.rdata, v);
    end
  endtask

  // One clock: drive inputs (called at a falling edge), cross the rising edge,
  // check at the next falling edge.
  task automatic clk_cycle(input logic w, input logic s, input logic [31:0] d);
    bus.we      = w;
    bus.reg_sel = s;
    bus.wdata   = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    bus.we = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) clk_cycle(1'b0, bus.reg_sel, 32'h0);
  endtask

  // Run until the scan sits at (idx, psc) before the coming edge; bounded.
  task automatic wait_scan(input string tag, input int idx, input int psc);
    for (int k = 0; k < 64; k++) begin
      if (m_idx == idx && m_psc == psc) break;
      clk_cycle(1'b0, bus.reg_sel, 32'h0);
    end
    n_cmp++;
    assert (m_idx == idx && m_psc == psc) else begin
      n_fail++;
      $error("FAIL %s: scan position idx=%0d psc=%0d, expected idx=%0d psc=%0d",
             tag, m_idx, m_psc, idx, psc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  seq_dig [5];
    logic [7:0]  seq_seg [5];
    int          lit0, lit2, blanks;
    logic        w, s;
    logic [31:0] d;

    m_data = '0;  m_en = 1'b1;  m_lzb = 1'b0;  m_dp = '0;
    m_idx = 0;  m_psc = 0;  m_dig = 4'hF;  m_seg = 8'hFF;
    rst = 1'b1;  bus.we = 1'b0;  bus.reg_sel = 1'b0;  bus.wdata = '0;

    // 1. Reset.
    clk_cycle(1'b0, 1'b1, 32'h0);
    expect_out("reset_cycle0", 4'b1111, 8'hFF);
    clk_cycle(1'b0, 1'b1, 32'h0);
    expect_out("reset_cycle1", 4'b1111, 8'hFF);
    rst = 1'b0;
    #1;
    expect_rdata("reset_ctrl_rdata", 32'h0000_0001);
    bus.reg_sel = 1'b0;
    #1;
    expect_rdata("reset_data_rdata", 32'h0000_0000);

    // 2. Scan order; the write lands on the first edge after release.
    clk_cycle(1'b1, 1'b0, 32'h0000_8F01);
    expect_out("first_after_reset", 4'b1110, 8'hC0);
    seq_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq_seg = '{8'hF9, 8'hC0, 8'h8E, 8'h80, 8'hF9};
    for (int k = 0; k < 19; k++) begin
      clk_cycle(1'b0, 1'b0, 32'h0);
      expect_out($sformatf("scan_k%0d", k), seq_dig[(k + 1) / 4], seq_seg[(k + 1) / 4]);
    end

    // 3. Leading-zero blanking.
    clk_cycle(1'b1, 1'b1, 32'h0000_0003);
    clk_cycle(1'b1, 1'b0, 32'h0000_0005);
    idle(1);
    lit0 = 0;  lit2 = 0;  blanks = 0;
    for (int k = 0; k < 16; k++) begin
      clk_cycle(1'b0, 1'b0, 32'h0);
      if (dig_en === 4'b1110 && seg === 8'h92) lit0++;
      if (dig_en === 4'b1111 && seg === 8'hFF) blanks++;
    end
    n_cmp++;
    assert (lit0 == 4 && blanks == 12) else begin
      n_fail++;
      $error("FAIL lzb_basic: digit0 cycles=%0d blank cycles=%0d, expected 4 and 12", lit0, blanks);
    end

    clk_cycle(1'b1, 1'b1, 32'h0000_0403);
    idle(1);
    lit0 = 0;  lit2 = 0;  blanks = 0;
    for (int k = 0; k < 16; k++) begin
      clk_cycle(1'b0, 1'b1, 32'h0);
      if (dig_en === 4'b1110 && seg === 8'h92) lit0++;
      if (dig_en === 4'b1011 && seg === 8'h40) lit2++;
      if (dig_en === 4'b1111 && seg === 8'hFF) blanks++;
    end
    n_cmp++;
    assert (lit0 == 4 && lit2 == 4 && blanks == 8) else begin
      n_fail++;
      $error("FAIL lzb_dp: d0=%0d d2=%0d blank=%0d cycles, expected 4 4 8", lit0, lit2, blanks);
    end

    // 4. Disable mid-slot on digit 2, then re-enable.
    wait_scan("wait_digit2", 2, 1);
    clk_cycle(1'b1, 1'b1, 32'h0000_0000);
    expect_out("disable_edge", 4'b1011, 8'h40);
    for (int k = 0; k < 20; k++) begin
      clk_cycle(1'b0, 1'b1, 32'h0);
      expect_out($sformatf("disabled_k%0d", k), 4'b1111, 8'hFF);
    end
    expect_rdata("disabled_ctrl_rdata", 32'h0000_0000);
    clk_cycle(1'b1, 1'b1, 32'h0000_0001);
    expect_out("enable_edge", 4'b1111, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      clk_cycle(1'b0, 1'b1, 32'h0);
      expect_out($sformatf("restart_slot_k%0d", k), 4'b1110, 8'h92);
    end
    clk_cycle(1'b0, 1'b1, 32'h0);
    expect_out("restart_next_digit", 4'b1101, 8'hC0);

    // 5. Write lands on the same edge as the 0 -> 1 advance.
    wait_scan("wait_tick0", 0, SD - 1);
    clk_cycle(1'b1, 1'b0, 32'h0000_00A0);
    clk_cycle(1'b0, 1'b0, 32'h0);
    expect_out("write_tick_collision", 4'b1101, 8'h88);

    // 6. Reset during the digit-3 slot.
    wait_scan("wait_digit3", 3, 1);
    rst = 1'b1;
    clk_cycle(1'b0, 1'b1, 32'h0);
    expect_out("midscan_reset", 4'b1111, 8'hFF);
    expect_rdata("midscan_reset_ctrl", 32'h0000_0001);
    bus.reg_sel = 1'b0;
    #1;
    expect_rdata("midscan_reset_data", 32'h0000_0000);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clk_cycle(1'b0, 1'b0, 32'h0);
      expect_out($sformatf("post_reset_k%0d", k), 4'b1110, 8'hC0);
    end
    clk_cycle(1'b0, 1'b0, 32'h0);
    expect_out("post_reset_next", 4'b1101, 8'hC0);

    // 7. Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      w   = ($urandom_range(0, 4) == 0);
      s   = 1'($urandom_range(0, 1));
      d   = $urandom();
      if (s) begin
        if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
        if ($urandom_range(0, 1) == 0) d[1] = 1'b1;
        if ($urandom_range(0, 1) == 0) d[15:8] = 8'h00;
      end else begin
        d = d >> (4 * $urandom_range(0, 8));
      end
      clk_cycle(w, s, d);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
Parametrised successor of the SoC 7-segment display peripheral. It drives up to 8 multiplexed common-anode digits from a bus-writable data register. A control register adds enable, leading-zero blanking and per-digit decimal points, and both registers read back. It sits behind the bridge's digit port and is clocked by cpu_clk.

Parameters:
NUM_DIGITS, 8, number of scanned digits, legal range 1..8
SCAN_DIV, 50000, clk cycles per digit slot, must be >= 2

Ports:
clk  input  1  bridge-supplied CPU clock
rst  input  1  synchronous, active-high reset
we  input  1  register write strobe, one cycle per write
reg_sel  input  1  register select: 0 = DATA, 1 = CTRL
wdata  input  32  write data
rdata  output  32  combinational read-back of the selected register
dig_en  output  NUM_DIGITS  digit enables, active low
seg  output  8  segments, active low: seg[0]=A … seg[6]=G, seg[7]=DP

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- DATA register (32 bit): nibble i, bits [4i+3:4i], is the hex value shown on digit i. Reset value 0. Bits above 4*NUM_DIGITS are stored and read back but not displayed.
- CTRL register:
  - bit0 EN, reset 1.
  - bit1 LZB (leading-zero blank), reset 0.
  - bits[15:8] DP mask, reset 0; bit 8+i lights DP on digit i.
  - Other bits read 0; writes to them are ignored.
- Writes: when we=1, the selected register takes wdata at the clock edge.
- rdata: reflects the register value after any write at the previous edge; no extra wait states.
- Prescaler: counts 0..SCAN_DIV-1.
  - tick = (prescaler == SCAN_DIV-1).
  - On tick, idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1, idx stays 0.
- Outputs are registered every cycle from the current idx, DATA and CTRL:
  - latency of 1 cycle after an idx change or a register write;
  - when a write and a tick land on the same edge, the next output uses both the new idx and the new data.
- Digit drive: only bit idx of dig_en is 0; seg = hex_to_seg(nibble idx) with DP = ~DP mask[idx].
- hex_to_seg (active low, DP bit=1), values 0..F:
  C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Leading-zero blanking, when LZB=1:
  - Digit i (i>0) is blanked if all nibbles i..NUM_DIGITS-1 are 0 and DP mask bit i is 0.
  - Digit 0 is never blanked.
  - A blanked slot drives dig_en all ones and seg=FF; the slot time is still consumed, so brightness stays uniform.
- EN=0:
  - dig_en all ones, seg=FF from the next edge on.
  - Prescaler and idx held at 0.
  - Re-enabling restarts scanning at digit 0 with a full slot.
- Reset values: prescaler=0, idx=0, dig_en all ones, seg=FF, registers as listed above. Reset mid-scan takes effect on the next edge, with no partial slot afterwards.
- Widths: prescaler is $clog2(SCAN_DIV) bits; idx is 3 bits; no other arithmetic.

Decomposition:
- Shared package (display_pkg):
  - register select constants REG_DATA=0, REG_CTRL=1;
  - CTRL bit positions EN_BIT, LZB_BIT, DP_LSB;
  - the 16-entry active-low segment table.
- One natural sub-module: seg7_decode, a combinational nibble-to-segment table lookup (4-bit in, 7-bit out).
- Prescaler, scan FSM, blanking logic and registers stay in hex_display_mux.

Test Plan (bench uses NUM_DIGITS=4, SCAN_DIV=4):
1. Reset check: assert rst for 2 cycles, then release → dig_en=4'b1111 and seg=8'hFF on the first edge. From the first edge after release, dig_en=4'b1110 and seg=C0. rdata with reg_sel=1 → 0x00000001.
2. Scan order: write DATA=0x0000_8F01 → slots of 4 cycles each show dig_en 1110/1101/1011/0111 with seg F9/C0/8E/80, then wrap to 1110/F9.
3. Leading-zero blanking: write CTRL=0x0000_0003 and DATA=0x0000_0005.
   - Digit 0 → seg 92.
   - Digits 1..3 → dig_en 1111, seg FF.
   - Then write CTRL=0x0000_0403 → digit 2 lit showing seg 40 (0 with DP); digits 1 and 3 stay blank.
4. Disable and restart: write CTRL=0 mid-slot on digit 2 → next edge dig_en=1111, seg=FF, held for 20 cycles. Write CTRL=1 → digit 0 shown for a full 4-cycle slot.
5. Write/tick collision: write DATA=0x0000_00A0 on the same edge that idx advances 0→1 → the next output is dig_en=1101, seg=88.
6. Reset mid-operation: assert rst during the digit-3 slot → next edge outputs 1111/FF and registers return to reset values. After release, scanning restarts at digit 0 showing C0.
